serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller. Sequences one full-adder cell across WIDTH-bit operands, one bit per clock.
//  Operands are captured on a START handshake. A registered carry is held between bit slots.
//  Presents SUM/COUT with a one-cycle DONE pulse. Sits between a register-file/ALU front end and the 1-bit adder datapath.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  CLK    in   1      system clock, rising-edge
//  RESET  in   1      asynchronous, active-high reset
//  START  in   1      request; sampled only in IDLE
//  A      in   WIDTH  operand A, captured when START accepted
//  B      in   WIDTH  operand B, captured when START accepted
//  CIN    in   1      carry-in, captured when START accepted
//  BUSY   out  1      high whenever state != IDLE
//  DONE   out  1      one-cycle pulse; SUM/COUT valid
//  SUM    out  WIDTH  result, registered; holds until the next completion
//  COUT   out  1      final carry, registered; holds with SUM
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high (ports CLK, RESET).
//  Reset: state=IDLE, count=0, carry=0, shift regs=0, BUSY=0, DONE=0, SUM=0, COUT=0.
//  FSM: IDLE -> SHIFT on START=1; SHIFT -> DONE_S when the last bit is processed; DONE_S -> IDLE unconditionally.
//  Accept edge (e0): START=1 in IDLE. Load A, B, CIN (carry reg <= CIN), count <= 0, go to SHIFT.
//  SHIFT edges e1..eWIDTH: fa_cell(a_sr[0], b_sr[0], carry) -> {c, s}.
//    Shift s into result_sr MSB, shift a_sr/b_sr right, carry <= c, count++.
//  At eWIDTH (count==WIDTH-1): SUM <= final result, COUT <= c, go to DONE_S.
//  DONE is a Moore output of DONE_S: high exactly between eWIDTH and eWIDTH+1.
//  Latency: DONE is high WIDTH cycles after the accept edge. Max throughput: one result per WIDTH+2 cycles (START held high).
//  START in SHIFT or DONE_S: ignored. No queueing. A/B/CIN changes after accept have no effect.
//  Arithmetic: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1); unsigned.
//  Counter width: $clog2(WIDTH). count never exceeds WIDTH-1.
//  RESET mid-operation: abandon the operation immediately. All outputs return to reset values; no DONE is issued.
//  SUM/COUT keep their last completed value while IDLE/SHIFT. They update only at eWIDTH.
// CONFIGURATION
//  Macro SERIAL_ADD_SUB_EN.
//  Defined: extra port SUB (in, 1), captured at accept.
//    SUB=1: B is complemented bitwise and the carry reg is forced to 1 (CIN ignored). SUM = A-B mod 2^WIDTH.
//    SUB=1: COUT=1 means no borrow (A>=B).
//    SUB=0: addition as above.
//  Undefined: SUB port absent; add-only; logic identical to SUB=0.
// STRUCTURE
//  Package serial_add_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE_S} sa_state_t; localparam SA_WIDTH_DEF = 8.
//  Sub-module fa_cell: purely combinational full adder.
//    Ports a, b, ci in; s, co out; {co,s} = a+b+ci.
//    One instance, in the bit slot.
//  Top level holds the FSM, counter, operand/result shift registers and the carry register.
// TESTING (WIDTH=8)
//  1 Assert RESET at 3rd SHIFT cycle of any op -> BUSY=0, DONE=0, SUM=00, COUT=0 immediately; no DONE afterwards.
//  2 A=5A, B=33, CIN=0, START 1 cycle -> BUSY for 9 cycles, DONE 8 cycles after accept, SUM=8D, COUT=0.
//  3 A=FF, B=01, CIN=0 -> SUM=00, COUT=1. Then A=FF, B=FF, CIN=1 -> SUM=FF, COUT=1.
//  4 Accept A=01, B=01; during SHIFT drive START=1, A=F0, B=0F -> ignored; SUM=02, single DONE.
//  5 START held high, ops back-to-back -> accepts every 10 cycles; DONE pulses 10 cycles apart; SUM holds between.
//  6 (SERIAL_ADD_SUB_EN) A=10, B=03, SUB=1 -> SUM=0D, COUT=1. A=03, B=10, SUB=1 -> SUM=F3, COUT=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// No configuration macros are used in this file.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE_S
  } sa_state_t;

  localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Purely combinational one-bit full adder used in the serial bit slot.
// No configuration macros are used in this file.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slot walked across WIDTH bits, one bit per clock.
// Optional macro SERIAL_ADD_SUB_EN adds a SUB port for A-B via inverted B and forced carry-in.
//
// state  | meaning
// IDLE   | waiting for START; SUM/COUT hold last result
// SHIFT  | processing one bit per clock, count 0..WIDTH-1
// DONE_S | DONE pulse; SUM/COUT freshly valid
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int CW = $clog2(WIDTH);

  sa_state_t        state;
  sa_state_t        state_nxt;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] result_sr;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is A + ~B + 1, so COUT=1 means no borrow.
  assign b_load = SUB ? ~B : B;
  assign c_load = SUB ? 1'b1 : CIN;
`else
  assign b_load = B;
  assign c_load = CIN;
`endif

  assign accept = (state == IDLE) && START;
  assign last   = (count == CW'(WIDTH - 1));

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    BUSY      = (state != IDLE);
    DONE      = (state == DONE_S);
    case (state)
      IDLE:    if (START) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE_S;
      DONE_S:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count     <= '0;
      carry     <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      result_sr <= '0;
      SUM       <= '0;
      COUT      <= 1'b0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= b_load;
      carry <= c_load;
      count <= '0;
    end else if (state == SHIFT) begin
      // Sum bits enter at the MSB so after WIDTH slots bit 0 sits at position 0.
      result_sr <= {fa_s, result_sr[WIDTH-1:1]};
      a_sr      <= a_sr >> 1;
      b_sr      <= b_sr >> 1;
      carry     <= fa_co;
      if (last) begin
        SUM   <= {fa_s, result_sr[WIDTH-1:1]};
        COUT  <= fa_co;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule
